// File: rtl/execute_cycle.sv
// execute_cycle: RV32I EX stage -- ALU, branch/jump resolution and the EX/MEM register.
// Define EXEC_FORWARD_EN to add operand forwarding from ALUResultM and ResultW.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [4:0]      RdE,
`ifdef EXEC_FORWARD_EN
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
`endif
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM
);

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_taken;

    logic            r_reg_write;
    logic            r_mem_write;
    logic [1:0]      r_result_src;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [XLEN-1:0] r_pc_plus4;
    logic [4:0]      r_rd;

`ifdef EXEC_FORWARD_EN
    // Select 11 is unused by the hazard unit and falls back to the register file value.
    always_comb begin
        case (ForwardAE)
            2'b10:   w_op_a = r_alu_result;
            2'b01:   w_op_a = ResultW;
            default: w_op_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b10:   w_op_b = r_alu_result;
            2'b01:   w_op_b = ResultW;
            default: w_op_b = RD2_E;
        endcase
    end
`else
    assign w_op_a = RD1_E;
    assign w_op_b = RD2_E;
`endif

    assign w_src_b = ALUSrcE ? ImmExtE : w_op_b;

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            3'b000: w_alu_result = w_op_a + w_src_b;
            3'b001: w_alu_result = w_op_a - w_src_b;
            3'b010: w_alu_result = w_op_a & w_src_b;
            3'b011: w_alu_result = w_op_a | w_src_b;
            3'b100: w_alu_result = w_op_a ^ w_src_b;
            3'b101: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_src_b))};
            3'b110: w_alu_result = w_op_a << w_src_b[4:0];
            3'b111: w_alu_result = w_op_a >> w_src_b[4:0];
            default: w_alu_result = '0;
        endcase
    end

    // Branch compare uses the register operands, never the immediate.
    always_comb begin
        w_taken = 1'b0;
        case (Funct3E)
            3'b000:  w_taken = (w_op_a == w_op_b);
            3'b001:  w_taken = (w_op_a != w_op_b);
            3'b100:  w_taken = ($signed(w_op_a) <  $signed(w_op_b));
            3'b101:  w_taken = ($signed(w_op_a) >= $signed(w_op_b));
            3'b110:  w_taken = (w_op_a <  w_op_b);
            3'b111:  w_taken = (w_op_a >= w_op_b);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_op_a + ImmExtE;
    assign PCSrcE     = (BranchE & w_taken) | JumpE | jalrE;
    assign PCTargetE  = jalrE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_alu_result <= w_alu_result;
            r_write_data <= w_op_b;
            r_pc_plus4   <= PCPlus4E;
            r_rd         <= RdE;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;
    assign RdM        = r_rd;

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized bench for execute_cycle against a behavioural model, plus literal directed checks.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic [31:0] PCE, PCPlus4E, ImmExtE, RD1_E, RD2_E;
    logic [4:0]  RdE;
`ifdef EXEC_FORWARD_EN
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
`endif
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model of the EX/MEM bundle
    logic        m_regw, m_memw;
    logic [1:0]  m_rsrc;
    logic [31:0] m_alu, m_wdata, m_pc4;
    logic [4:0]  m_rd;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .jalrE(jalrE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ResultSrcE(ResultSrcE), .Funct3E(Funct3E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .RD1_E(RD1_E), .RD2_E(RD2_E), .RdE(RdE),
`ifdef EXEC_FORWARD_EN
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`endif
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_opa();
`ifdef EXEC_FORWARD_EN
        if (ForwardAE == 2'b10) return m_alu;
        if (ForwardAE == 2'b01) return ResultW;
`endif
        return RD1_E;
    endfunction

    function automatic logic [31:0] m_opb();
`ifdef EXEC_FORWARD_EN
        if (ForwardBE == 2'b10) return m_alu;
        if (ForwardBE == 2'b01) return ResultW;
`endif
        return RD2_E;
    endfunction

    function automatic logic [31:0] m_alu_fn(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (ALUControlE)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    function automatic bit m_taken(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (Funct3E)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_regw <= 0; m_memw <= 0; m_rsrc <= 0; m_alu <= 0;
            m_wdata <= 0; m_pc4 <= 0; m_rd <= 0;
        end else begin
            m_regw  <= RegWriteE;
            m_memw  <= MemWriteE;
            m_rsrc  <= ResultSrcE;
            m_alu   <= m_alu_fn(m_opa(), ALUSrcE ? ImmExtE : m_opb());
            m_wdata <= m_opb();
            m_pc4   <= PCPlus4E;
            m_rd    <= RdE;
        end
    end

    // Compare process: every negedge once the model has been reset alongside the DUT.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] a;
            a = m_opa();
            chk("m_pcsrc", {31'b0, PCSrcE},
                {31'b0, (BranchE && m_taken(a, m_opb())) || JumpE || jalrE});
            chk("m_target", PCTargetE, jalrE ? ((a + ImmExtE) & ~32'h1) : (PCE + ImmExtE));
            chk("m_regw", {31'b0, RegWriteM}, {31'b0, m_regw});
            chk("m_memw", {31'b0, MemWriteM}, {31'b0, m_memw});
            chk("m_rsrc", {30'b0, ResultSrcM}, {30'b0, m_rsrc});
            chk("m_alu", ALUResultM, m_alu);
            chk("m_wdata", WriteDataM, m_wdata);
            chk("m_pc4", PCPlus4M, m_pc4);
            chk("m_rd", {27'b0, RdM}, {27'b0, m_rd});
        end
    end

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; jalrE = 0; BranchE = 0; ALUSrcE = 0;
        ALUControlE = 0; ResultSrcE = 0; Funct3E = 0; PCE = 0; PCPlus4E = 0;
        ImmExtE = 0; RD1_E = 0; RD2_E = 0; RdE = 0;
`ifdef EXEC_FORWARD_EN
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
`endif
    endtask

    task automatic random_inputs();
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
        JumpE = ($urandom_range(0, 7) == 0); jalrE = ($urandom_range(0, 7) == 0);
        BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
        ALUControlE = 3'($urandom); ResultSrcE = 2'($urandom); Funct3E = 3'($urandom);
        PCE = $urandom; PCPlus4E = PCE + 4; ImmExtE = $urandom;
        RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        RdE = 5'($urandom);
`ifdef EXEC_FORWARD_EN
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
`endif
    endtask

    // Advance one edge; returns at negedge+1 with the new registered outputs settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        RegWriteE = 1; RD1_E = 32'd5;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_regw", {31'b0, RegWriteM}, 32'd0);
            chk("rst_memw", {31'b0, MemWriteM}, 32'd0);
            chk("rst_alu", ALUResultM, 32'd0);
            chk("rst_wdata", WriteDataM, 32'd0);
            chk("rst_pc4", PCPlus4M, 32'd0);
            chk("rst_rd", {27'b0, RdM}, 32'd0);
        end
        chk_en = 1'b1;
        rst = 1'b1;

        clear_inputs();
        RD1_E = 32'd7; ImmExtE = 32'd5; ALUSrcE = 1; RdE = 5'd3; RegWriteE = 1;
        step();
        chk("add_alu", ALUResultM, 32'd12);
        chk("add_rd", {27'b0, RdM}, 32'd3);
        chk("add_regw", {31'b0, RegWriteM}, 32'd1);

        clear_inputs();
        RD1_E = 32'd1; RD2_E = 32'd2; BranchE = 1; Funct3E = 3'b001;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        chk("bne_pcsrc", {31'b0, PCSrcE}, 32'd1);
        chk("bne_target", PCTargetE, 32'h0000_00F8);
        Funct3E = 3'b000;
        #1;
        chk("beq_pcsrc", {31'b0, PCSrcE}, 32'd0);
        step();

        clear_inputs();
        RD1_E = 32'h203; ImmExtE = 32'h10; jalrE = 1; PCPlus4E = 32'h44;
        #1;
        chk("jalr_pcsrc", {31'b0, PCSrcE}, 32'd1);
        chk("jalr_target", PCTargetE, 32'h212);
        step();
        chk("jalr_pc4", PCPlus4M, 32'h44);

        clear_inputs();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControlE = 3'b101;
        BranchE = 1; Funct3E = 3'b110;
        #1;
        chk("bltu_pcsrc", {31'b0, PCSrcE}, 32'd0);
        step();
        chk("slt_alu", ALUResultM, 32'd1);

`ifdef EXEC_FORWARD_EN
        clear_inputs();
        RD1_E = 32'd4; ImmExtE = 32'd5; ALUSrcE = 1;
        step();
        chk("fwd_prior", ALUResultM, 32'd9);
        clear_inputs();
        RD1_E = 32'd100; RD2_E = 32'd200; ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 32'd1;
        ForwardBE = 2'b01; ResultW = 32'h55;
        step();
        chk("fwd_alu", ALUResultM, 32'd10);
        chk("fwd_wdata", WriteDataM, 32'h55);
`endif

        for (int i = 0; i < 2000; i++) begin
            random_inputs();
            rst = ($urandom_range(0, 31) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
